angle_servo_ctrl: RTL and testbench
===================================

// Module: angle_servo_ctrl
// PURPOSE
//  Closed-loop positioning stage between the AS5600 I2C reader and the PWM driver. Captures each
//  12-bit raw_angle on the reader's rd_done pulse and computes the shortest-path error to a
//  commanded target, including 4095->0 wrap. Drives direction and duty to the PWM driver and
//  returns angle_done, which gates the reader's polling. Flags a stall if the target is not reached in time.
// PARAMETERS
//  TOLERANCE     12'd8    max |error| (counts) treated as on-target
//  SETTLE_CNT    4'd3     consecutive on-target samples required before done (1..15)
//  TIMEOUT_SMP   16'd2000 samples allowed in MOVE/SETTLE before stall_fault
//  MIN_DUTY      8'd20    duty floor while moving
//  MAX_DUTY      8'd255   duty ceiling
//  DUTY_SHIFT    3'd2     proportional gain: duty_raw = |error| >> DUTY_SHIFT
// PORTS
//  clock         in   1   main clock, single domain
//  reset         in   1   synchronous reset, active high
//  start         in   1   one-cycle pulse: latch target_angle, begin move
//  target_angle  in   12  commanded angle, 0..4095
//  raw_angle     in   12  angle from I2C reader, valid when rd_done=1
//  rd_done       in   1   one-cycle sample-valid pulse from I2C reader
//  angle_done    out  1   1 = on target / idle / faulted (reader stops polling)
//  busy          out  1   1 in MOVE or SETTLE
//  dir           out  1   1 = increasing angle (CW), 0 = decreasing
//  duty          out  8   PWM duty to motor driver, 0 = stopped
//  err_mag       out  12  |shortest error| of last evaluated sample
//  stall_fault   out  1   sticky until next start
// BEHAVIOUR
//  Reset values: angle_done=1, busy=0, dir=0, duty=0, err_mag=0, stall_fault=0, state=IDLE, counters=0.
//  Reset asserted mid-move returns to these values at the next clock edge; the target is discarded.
//  Error arithmetic: diff = (target - sample) mod 4096 (12-bit unsigned subtract).
//   If diff[11]=0: dir=1, mag=diff. Otherwise dir=0, mag=4096-diff.
//   diff=2048 gives dir=0, mag=2048.
//  Duty: mag<=TOLERANCE -> 0. Otherwise clamp(mag>>DUTY_SHIFT, MIN_DUTY, MAX_DUTY).
//  Pipeline: sample registered on cycle N (rd_done high). diff/mag are registered on N+1.
//   dir/duty/err_mag/state update on N+2. Total latency from rd_done to outputs: 2 cycles.
//  States:
//   IDLE:   angle_done=1, duty=0. On start -> MOVE.
//   MOVE:   busy=1, angle_done=0. On each evaluated sample, timeout_cnt++.
//           If mag<=TOLERANCE: settle_cnt=1; if SETTLE_CNT==1 -> DONE, else -> SETTLE.
//   SETTLE: duty=0. On an on-target sample, settle_cnt++; reaching SETTLE_CNT -> DONE.
//           On an off-target sample: settle_cnt=0 -> MOVE.
//   DONE:   angle_done=1, busy=0, duty=0, dir holds. On start -> MOVE.
//   FAULT:  entered when timeout_cnt reaches TIMEOUT_SMP in MOVE/SETTLE.
//           stall_fault=1, angle_done=1, duty=0. On start -> MOVE and stall_fault clears.
//  On start: target latched; settle_cnt and timeout_cnt clear; angle_done drops on the next cycle.
//   Pipeline stages in flight are discarded.
//  Simultaneous events:
//   start + rd_done in the same cycle: start wins and the sample is dropped.
//   start while busy: retarget and restart counters, stay in MOVE.
//   Timeout and on-target on the same sample: DONE wins.
//  Samples arriving in IDLE/DONE/FAULT are captured into err_mag only; outputs stay unchanged.
//  timeout_cnt saturates at TIMEOUT_SMP and does not wrap.
// TESTING
//  T1 wrap: target=10, raw=4090, start then rd_done -> 2 cycles later dir=1, err_mag=16, duty=20.
//  T2 half-turn tie: target=2048, raw=0 -> dir=0, err_mag=2048, duty=255 (512 clamped).
//  T3 settle: target=1000; raws 995,1003,1001 on three rd_done pulses -> SETTLE, then DONE.
//     angle_done=1 and duty=0 two cycles after the third pulse. Variant 995,1020,1001 re-enters MOVE on 1020.
//  T4 stall: TIMEOUT_SMP=4, target=0, raw fixed at 2000 -> stall_fault=1, angle_done=1 after the 4th sample.
//     A following start clears stall_fault.
//  T5 collisions: start and rd_done in the same cycle -> sample ignored. Retarget mid-MOVE -> counters reset,
//     new dir/duty on the next sample.
//  T6 reset mid-SETTLE: reset for 1 cycle -> all outputs at reset values next edge; later rd_done pulses are ignored.

Source files
------------

// File: rtl/angle_servo_ctrl_if.sv
// Control/status bundle between the angle servo controller and its surroundings
// (I2C angle reader, PWM driver and the sequencer that issues start/target).
interface angle_servo_ctrl_if;
  logic        start;
  logic [11:0] target_angle;
  logic [11:0] raw_angle;
  logic        rd_done;
  logic        angle_done;
  logic        busy;
  logic        dir;
  logic [7:0]  duty;
  logic [11:0] err_mag;
  logic        stall_fault;

  modport master (
    output start, target_angle, raw_angle, rd_done,
    input  angle_done, busy, dir, duty, err_mag, stall_fault
  );

  modport slave (
    input  start, target_angle, raw_angle, rd_done,
    output angle_done, busy, dir, duty, err_mag, stall_fault
  );
endinterface

// File: rtl/angle_servo_ctrl.sv
// Closed-loop angle positioning: shortest-path error to target (with 4095->0 wrap),
// proportional duty with floor/ceiling, settle qualification and stall timeout.
//
//  state  | meaning
//  IDLE   | no target yet, motor stopped, reader may idle
//  MOVE   | driving toward target, duty follows |error|
//  SETTLE | on target, counting consecutive on-target samples, motor stopped
//  DONE   | target reached and qualified, dir holds, motor stopped
//  FAULT  | timeout expired before reaching target, stall_fault set
module angle_servo_ctrl #(
  parameter logic [11:0] TOLERANCE   = 12'd8,
  parameter logic [3:0]  SETTLE_CNT  = 4'd3,
  parameter logic [15:0] TIMEOUT_SMP = 16'd2000,
  parameter logic [7:0]  MIN_DUTY    = 8'd20,
  parameter logic [7:0]  MAX_DUTY    = 8'd255,
  parameter logic [2:0]  DUTY_SHIFT  = 3'd2
) (
  input logic               clk_i,
  input logic               rst_i,
  angle_servo_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_SETTLE,
    S_DONE,
    S_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] target_q, target_d;
  logic [11:0] sample_q, sample_d;
  logic        smp_vld_q, smp_vld_d;
  logic [11:0] mag_q, mag_d;
  logic        dirc_q, dirc_d;
  logic        eval_vld_q, eval_vld_d;
  logic        dir_q, dir_d;
  logic [7:0]  duty_q, duty_d;
  logic [11:0] err_mag_q, err_mag_d;
  logic        stall_q, stall_d;
  logic [3:0]  settle_q, settle_d;
  logic [15:0] tmo_q, tmo_d;

  logic [11:0] diff;
  logic [11:0] shifted;
  logic [7:0]  duty_clamped;
  logic        on_tgt;
  logic [15:0] tmo_inc;
  logic [3:0]  settle_nx;

  assign diff    = target_q - sample_q;
  assign shifted = mag_q >> DUTY_SHIFT;
  assign on_tgt  = (mag_q <= TOLERANCE);
  assign tmo_inc = (tmo_q >= TIMEOUT_SMP) ? tmo_q : tmo_q + 16'd1;

  always_comb begin
    duty_clamped = shifted[7:0];
    if (on_tgt)
      duty_clamped = 8'd0;
    else if (shifted < {4'd0, MIN_DUTY})
      duty_clamped = MIN_DUTY;
    else if (shifted > {4'd0, MAX_DUTY})
      duty_clamped = MAX_DUTY;
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    sample_d   = sample_q;
    smp_vld_d  = 1'b0;
    mag_d      = mag_q;
    dirc_d     = dirc_q;
    eval_vld_d = smp_vld_q;
    dir_d      = dir_q;
    duty_d     = duty_q;
    err_mag_d  = err_mag_q;
    stall_d    = stall_q;
    settle_d   = settle_q;
    tmo_d      = tmo_q;
    settle_nx  = settle_q;

    if (smp_vld_q) begin
      dirc_d = ~diff[11];
      mag_d  = diff[11] ? (12'd0 - diff) : diff;
    end

    if (bus.start) begin
      // Retarget from any state; samples already in the pipeline are stale.
      target_d   = bus.target_angle;
      smp_vld_d  = 1'b0;
      eval_vld_d = 1'b0;
      settle_d   = 4'd0;
      tmo_d      = 16'd0;
      stall_d    = 1'b0;
      state_d    = S_MOVE;
    end else begin
      if (bus.rd_done) begin
        sample_d  = bus.raw_angle;
        smp_vld_d = 1'b1;
      end
      if (eval_vld_q) begin
        err_mag_d = mag_q;
        if (state_q == S_MOVE || state_q == S_SETTLE) begin
          dir_d = dirc_q;
          tmo_d = tmo_inc;
          if (on_tgt) begin
            settle_nx = (state_q == S_MOVE) ? 4'd1 : settle_q + 4'd1;
            settle_d  = settle_nx;
            duty_d    = 8'd0;
            state_d   = (settle_nx >= SETTLE_CNT) ? S_DONE : S_SETTLE;
          end else begin
            settle_d = 4'd0;
            duty_d   = duty_clamped;
            state_d  = S_MOVE;
          end
          // Reaching target on the final allowed sample still counts as success.
          if (state_d != S_DONE && tmo_inc >= TIMEOUT_SMP) begin
            state_d = S_FAULT;
            duty_d  = 8'd0;
            stall_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      target_q   <= 12'd0;
      sample_q   <= 12'd0;
      smp_vld_q  <= 1'b0;
      mag_q      <= 12'd0;
      dirc_q     <= 1'b0;
      eval_vld_q <= 1'b0;
      dir_q      <= 1'b0;
      duty_q     <= 8'd0;
      err_mag_q  <= 12'd0;
      stall_q    <= 1'b0;
      settle_q   <= 4'd0;
      tmo_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      sample_q   <= sample_d;
      smp_vld_q  <= smp_vld_d;
      mag_q      <= mag_d;
      dirc_q     <= dirc_d;
      eval_vld_q <= eval_vld_d;
      dir_q      <= dir_d;
      duty_q     <= duty_d;
      err_mag_q  <= err_mag_d;
      stall_q    <= stall_d;
      settle_q   <= settle_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.angle_done  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAULT);
  assign bus.busy        = (state_q == S_MOVE) || (state_q == S_SETTLE);
  assign bus.dir         = dir_q;
  assign bus.duty        = duty_q;
  assign bus.err_mag     = err_mag_q;
  assign bus.stall_fault = stall_q;

endmodule

// File: tb/tb_angle_servo_ctrl.sv
// Bench for angle_servo_ctrl: directed scenarios, a queue-based reference model
// checked every cycle, and literal expectations at key points.
module tb_angle_servo_ctrl;
  localparam int TOL = 8;
  localparam int SCNT = 3;
  localparam int TMO = 4;

  localparam int M_IDLE = 0, M_MOVE = 1, M_SETTLE = 2, M_DONE = 3, M_FAULT = 4;

  logic clk;
  logic rst;
  angle_servo_ctrl_if sif ();

  angle_servo_ctrl #(.TIMEOUT_SMP(16'd4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: samples wait in a queue for their due cycle (two edges after capture).
  typedef struct { int due; int raw; } pend_t;
  pend_t pend[$];
  int cyc = 0;
  int m_mode, m_target, m_dir, m_duty, m_err, m_stall, m_settle, m_tmo;

  task automatic model_reset();
    m_mode = M_IDLE; m_target = 0; m_dir = 0; m_duty = 0; m_err = 0;
    m_stall = 0; m_settle = 0; m_tmo = 0;
    pend.delete();
  endtask

  task automatic model_apply(input int s);
    int d, mag, dr, sat;
    d = (m_target - s + 4096) % 4096;
    if (d < 2048) begin dr = 1; mag = d; end
    else begin dr = 0; mag = 4096 - d; end
    m_err = mag;
    if (m_mode == M_MOVE || m_mode == M_SETTLE) begin
      m_dir = dr;
      if (m_tmo < TMO) m_tmo++;
      if (mag <= TOL) begin
        m_settle = (m_mode == M_MOVE) ? 1 : m_settle + 1;
        m_duty = 0;
        m_mode = (m_settle >= SCNT) ? M_DONE : M_SETTLE;
      end else begin
        m_settle = 0;
        sat = mag / 4;
        if (sat < 20) sat = 20;
        if (sat > 255) sat = 255;
        m_duty = sat;
        m_mode = M_MOVE;
      end
      if (m_mode != M_DONE && m_tmo >= TMO) begin
        m_mode = M_FAULT; m_duty = 0; m_stall = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) model_reset();
      else if (sif.start) begin
        pend.delete();
        m_target = int'(sif.target_angle);
        m_mode = M_MOVE; m_settle = 0; m_tmo = 0; m_stall = 0;
      end else begin
        while (pend.size() > 0 && pend[0].due == cyc) begin
          model_apply(pend[0].raw);
          void'(pend.pop_front());
        end
        if (sif.rd_done) pend.push_back('{due: cyc + 2, raw: int'(sif.raw_angle)});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc_angle_done", int'(sif.angle_done),
            int'(m_mode == M_IDLE || m_mode == M_DONE || m_mode == M_FAULT));
        chk("cyc_busy", int'(sif.busy), int'(m_mode == M_MOVE || m_mode == M_SETTLE));
        chk("cyc_dir", int'(sif.dir), m_dir);
        chk("cyc_duty", int'(sif.duty), m_duty);
        chk("cyc_err_mag", int'(sif.err_mag), m_err);
        chk("cyc_stall", int'(sif.stall_fault), m_stall);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input int t);
    sif.target_angle = 12'(t);
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
  endtask

  task automatic sample(input int r);
    sif.raw_angle = 12'(r);
    sif.rd_done = 1'b1;
    tick();
    sif.rd_done = 1'b0;
  endtask

  task automatic sample_wait(input int r);
    sample(r);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sif.start = 1'b0; sif.rd_done = 1'b0;
    sif.target_angle = 12'd0; sif.raw_angle = 12'd0;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_angle_done", int'(sif.angle_done), 1);
    chk("rst_busy", int'(sif.busy), 0);
    chk("rst_dir", int'(sif.dir), 0);
    chk("rst_duty", int'(sif.duty), 0);
    chk("rst_err_mag", int'(sif.err_mag), 0);
    chk("rst_stall", int'(sif.stall_fault), 0);
    rst = 1'b0;
    tick();

    // T1 wrap
    do_start(10);
    chk("t1_angle_done_drop", int'(sif.angle_done), 0);
    sample_wait(4090);
    chk("t1_dir", int'(sif.dir), 1);
    chk("t1_err_mag", int'(sif.err_mag), 16);
    chk("t1_duty", int'(sif.duty), 20);

    // T2 half-turn tie
    do_start(2048);
    sample_wait(0);
    chk("t2_dir", int'(sif.dir), 0);
    chk("t2_err_mag", int'(sif.err_mag), 2048);
    chk("t2_duty", int'(sif.duty), 255);

    // T3 settle to DONE, then a sample while DONE
    do_start(1000);
    sample_wait(995);
    chk("t3_settle_busy", int'(sif.busy), 1);
    chk("t3_settle_duty", int'(sif.duty), 0);
    sample_wait(1003);
    sample_wait(1001);
    chk("t3_done_angle_done", int'(sif.angle_done), 1);
    chk("t3_done_busy", int'(sif.busy), 0);
    chk("t3_done_duty", int'(sif.duty), 0);
    chk("t3_done_dir", int'(sif.dir), 0);
    sample_wait(900);
    chk("t3_idle_err_mag", int'(sif.err_mag), 100);
    chk("t3_dir_hold", int'(sif.dir), 0);
    chk("t3_still_done", int'(sif.angle_done), 1);

    // T3 variant: off-target sample drops back to MOVE
    do_start(1000);
    sample_wait(995);
    sample_wait(1020);
    chk("t3v_busy", int'(sif.busy), 1);
    chk("t3v_duty", int'(sif.duty), 20);
    chk("t3v_dir", int'(sif.dir), 0);
    chk("t3v_err_mag", int'(sif.err_mag), 20);
    sample_wait(1001);

    // T4 stall
    do_start(0);
    sample_wait(2000);
    sample_wait(2000);
    sample_wait(2000);
    chk("t4_pre_busy", int'(sif.busy), 1);
    chk("t4_pre_duty", int'(sif.duty), 255);
    chk("t4_pre_stall", int'(sif.stall_fault), 0);
    sample_wait(2000);
    chk("t4_stall", int'(sif.stall_fault), 1);
    chk("t4_angle_done", int'(sif.angle_done), 1);
    chk("t4_duty", int'(sif.duty), 0);
    do_start(0);
    chk("t4_stall_clear", int'(sif.stall_fault), 0);
    chk("t4_restart_busy", int'(sif.busy), 1);

    // T5 start and rd_done in the same cycle: sample dropped
    sif.target_angle = 12'd100; sif.raw_angle = 12'd50;
    sif.start = 1'b1; sif.rd_done = 1'b1;
    tick();
    sif.start = 1'b0; sif.rd_done = 1'b0;
    tick(); tick();
    chk("t5_drop_err_mag", int'(sif.err_mag), 2000);
    chk("t5_drop_busy", int'(sif.busy), 1);
    sample_wait(90);
    chk("t5_dir", int'(sif.dir), 1);
    chk("t5_err_mag", int'(sif.err_mag), 10);
    chk("t5_duty", int'(sif.duty), 20);
    sample_wait(90);
    sample_wait(90);
    do_start(3000);
    sample_wait(90);
    chk("t5_rt_dir", int'(sif.dir), 0);
    chk("t5_rt_duty", int'(sif.duty), 255);
    chk("t5_rt_err_mag", int'(sif.err_mag), 1186);
    sample_wait(90);
    sample_wait(90);
    chk("t5_rt_no_stall", int'(sif.stall_fault), 0);
    chk("t5_rt_busy", int'(sif.busy), 1);

    // T6 reset mid-SETTLE
    do_start(500);
    sample_wait(500);
    chk("t6_settle_busy", int'(sif.busy), 1);
    rst = 1'b1;
    tick();
    chk("t6_angle_done", int'(sif.angle_done), 1);
    chk("t6_busy", int'(sif.busy), 0);
    chk("t6_dir", int'(sif.dir), 0);
    chk("t6_duty", int'(sif.duty), 0);
    chk("t6_err_mag", int'(sif.err_mag), 0);
    chk("t6_stall", int'(sif.stall_fault), 0);
    rst = 1'b0;
    sample_wait(0);
    chk("t6_post_angle_done", int'(sif.angle_done), 1);
    chk("t6_post_busy", int'(sif.busy), 0);
    chk("t6_post_duty", int'(sif.duty), 0);
    chk("t6_post_err_mag", int'(sif.err_mag), 0);
    tick(); tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
